dsp_coef_mem: RTL and testbench
===============================

Name: dsp_coef_mem

Overview:
- Coefficient/sample store that answers the dsp block's memory read port: dsp drives memaddr, this block returns memdout.
- Host side loads words through a simple write port.
- After reset or a clear request, a sequencer fills every location with a fixed value before the store accepts host writes.
- Sits beside each dsp instance and replaces the ad-hoc memdout wiring.

Parameters:
- ADDR_W, 6, address width; depth = 2**ADDR_W.
- DATA_W, 14, word width.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- INIT_VAL, 0, DATA_W-bit value written to every location during init.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  read enable; when low, the read pipeline holds.
- memaddr  in  ADDR_W  read address from dsp.
- memdout  out  DATA_W  read data to dsp.
- host_addr  in  ADDR_W  write address.
- host_din  in  DATA_W  write data.
- host_we  in  1  write request.
- host_ack  out  1  write accepted; asserted in the cycle the write happens.
- clr  in  1  request re-initialisation.
- ready  out  1  high in RUN state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values (cycle after rst high): state=INIT, init counter=0, memdout=0, all read pipeline registers=0, host_ack=0, ready=0. Array contents are not reset directly; the INIT sequence rewrites them.
- INIT state:
  - Each cycle writes INIT_VAL to location cnt, then cnt increments.
  - After cnt = 2**ADDR_W-1 is written, the next state is RUN. INIT takes exactly 2**ADDR_W cycles.
  - host_we is ignored and host_ack stays 0.
- Reads during INIT: return INIT_VAL with normal latency, regardless of array contents.
- RUN state:
  - host_we=1 writes host_din to host_addr that edge.
  - host_ack=1 in the same cycle (combinational from host_we and state). No back-pressure in RUN.
- clr:
  - clr=1 in RUN moves to INIT on the next edge and resets cnt=0; ready drops that edge.
  - clr in INIT restarts the count from 0.
  - A host write in the same cycle as clr in RUN is still performed (host_ack=1), then overwritten by INIT.
- Read path with en=1:
  - Address is sampled at edge N.
  - RD_LAT=1: memdout is valid after edge N.
  - RD_LAT=2: an extra output register, so memdout is valid after edge N+1.
  - With en=0, all read registers hold their values.
- Read/write collision: if memaddr == host_addr and host_ack=1 in the same cycle, the read returns the new host_din (write-first forwarding). The same applies to INIT writes: the read returns INIT_VAL.
- rst mid-INIT or mid-RUN: restarts INIT from 0; memdout clears to 0 and then returns INIT_VAL for reads.
- Address wrap: addresses are ADDR_W bits wide, so there is no out-of-range case. The init counter does not wrap into RUN early.
- Width rules: no arithmetic on data. The counter is ADDR_W+1 bits, and completion is detected on the MSB or the terminal count.

Decomposition:
- Shared package dsp_mem_pkg holds:
  - state encoding constants ST_INIT, ST_RUN;
  - default ADDR_W=6 and DATA_W=14, matching dsp memaddr/memdout.
- One sub-module, dsp_coef_ram: a single-clock array with one write port and one registered read port, and no reset on the array.
- The top holds the INIT sequencer, the collision mux and the optional RD_LAT=2 output stage.

Test Plan:
- Reset and init: pulse rst for 1 cycle.
  - ready=0 for exactly 64 cycles, then 1.
  - host_ack=0 throughout INIT.
  - Reading addresses 0..63 afterwards returns 0x0000.
- Write then read: in RUN, write host_addr=5, host_din=0x2A5A; read memaddr=5 the next cycle.
  - RD_LAT=1: memdout=0x2A5A one edge after sampling.
  - RD_LAT=2: memdout=0x2A5A two edges after sampling.
- Collision: memaddr=host_addr=9, host_din=0x1234 with host_we in the same cycle → memdout=0x1234 at the normal latency.
- en hold: set memaddr=5 then memaddr=6 with en=0 → memdout keeps its prior value. Raising en resumes reads with correct latency.
- clr mid-run: write 0x3FFF to address 63, then assert clr.
  - ready drops the next edge and stays low for 64 cycles.
  - Address 63 then reads 0x0000.
  - A host_we during INIT gets host_ack=0 and is not stored.
- rst mid-INIT: assert rst at init count 30 → INIT restarts and takes a full 64 cycles. Set INIT_VAL=0x0155 in a second build → all addresses read 0x0155.

Source files
------------

// File: rtl/dsp_mem_pkg.sv
// rtl/dsp_mem_pkg.sv - shared constants and state encoding for the dsp coefficient store
package dsp_mem_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 14;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dsp_coef_mem_if.sv
// rtl/dsp_coef_mem_if.sv - dsp read port plus host write port of the coefficient store
interface dsp_coef_mem_if
  import dsp_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              en;
  logic [ADDR_W-1:0] memaddr;
  logic [DATA_W-1:0] memdout;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic              host_we;
  logic              host_ack;

  modport master (
    output en, memaddr, host_addr, host_din, host_we,
    input  memdout, host_ack
  );

  modport slave (
    input  en, memaddr, host_addr, host_din, host_we,
    output memdout, host_ack
  );

endinterface

// File: rtl/dsp_coef_ram.sv
// rtl/dsp_coef_ram.sv - single-clock array, one write port, one registered read port
module dsp_coef_ram
  import dsp_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read returns the old contents on a same-address write; the top forwards around it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dsp_coef_mem.sv
// rtl/dsp_coef_mem.sv - coefficient store: init sequencer, write-first forwarding, optional output stage
module dsp_coef_mem
  import dsp_mem_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  output logic           ready,
  dsp_coef_mem_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH-1);

  state_e            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic              ready_q;

  logic              in_init;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fwd_d, fwd_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] stage1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (clr) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign ready        = ready_q;
  assign in_init      = (state_q == ST_INIT);
  assign bus.host_ack = bus.host_we & ~in_init;

  assign wr_en   = in_init | bus.host_we;
  assign wr_addr = in_init ? cnt_q[ADDR_W-1:0] : bus.host_addr;
  assign wr_data = in_init ? INIT_VAL : bus.host_din;

  // During INIT every read sees INIT_VAL, which is also the data being written.
  assign fwd_d = in_init | (wr_en & (wr_addr == bus.memaddr));

  dsp_coef_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (bus.en),
    .raddr_i (bus.memaddr),
    .rdata_o (ram_rdata)
  );

  // Reset selects the forward path with zero data so memdout clears without resetting the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= 1'b1;
      fwd_data_q <= '0;
    end else if (bus.en) begin
      fwd_q      <= fwd_d;
      fwd_data_q <= wr_data;
    end
  end

  assign stage1 = fwd_q ? fwd_data_q : ram_rdata;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clk) begin
        if (rst)         out_q <= '0;
        else if (bus.en) out_q <= stage1;
      end
      assign bus.memdout = out_q;
    end else begin : g_lat1
      assign bus.memdout = stage1;
    end
  endgenerate

endmodule

// File: tb/tb_dsp_coef_mem.sv
// tb/tb_dsp_coef_mem.sv - randomized bench for dsp_coef_mem against a behavioural store model
module tb_dsp_coef_mem;

  localparam logic [13:0] IV1 = 14'h0000;
  localparam logic [13:0] IV2 = 14'h0155;

  logic        clk = 1'b0;
  logic        rst, clr, en, host_we;
  logic [5:0]  memaddr, host_addr;
  logic [13:0] host_din;
  logic        ready1, ready2;

  int checks = 0;
  int errors = 0;

  logic [13:0] m1 [64];
  logic [13:0] m2 [64];
  int          rem;
  logic [13:0] p1a, p2a, p1b, p2b;

  always #5 clk = ~clk;

  dsp_coef_mem_if #(.ADDR_W(6), .DATA_W(14)) if1 ();
  dsp_coef_mem_if #(.ADDR_W(6), .DATA_W(14)) if2 ();

  assign if1.en = en;  assign if1.memaddr = memaddr;  assign if1.host_addr = host_addr;
  assign if1.host_din = host_din;  assign if1.host_we = host_we;
  assign if2.en = en;  assign if2.memaddr = memaddr;  assign if2.host_addr = host_addr;
  assign if2.host_din = host_din;  assign if2.host_we = host_we;

  dsp_coef_mem #(.ADDR_W(6), .DATA_W(14), .RD_LAT(1), .INIT_VAL(IV1)) u_lat1 (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready1), .bus(if1.slave)
  );

  dsp_coef_mem #(.ADDR_W(6), .DATA_W(14), .RD_LAT(2), .INIT_VAL(IV2)) u_lat2 (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready2), .bus(if2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already applied; advances one clock.
  task automatic tick();
    logic        exp_ack;
    logic [13:0] rv1, rv2;
    #1;
    exp_ack = host_we && (rem == 0);
    if (!rst) begin
      chk("host_ack_lat1", 32'(if1.host_ack), 32'(exp_ack));
      chk("host_ack_lat2", 32'(if2.host_ack), 32'(exp_ack));
    end
    if (rst) begin
      rem = 64;
      p1a = '0; p2a = '0; p1b = '0; p2b = '0;
    end else begin
      if (rem == 0) begin
        if (host_we) begin
          m1[host_addr] = host_din;
          m2[host_addr] = host_din;
        end
        rv1 = m1[memaddr];
        rv2 = m2[memaddr];
        if (clr) rem = 64;
      end else begin
        rv1 = IV1;
        rv2 = IV2;
        if (clr) rem = 64;
        else begin
          rem--;
          if (rem == 0)
            for (int i = 0; i < 64; i++) begin
              m1[i] = IV1;
              m2[i] = IV2;
            end
        end
      end
      if (en) begin
        p2a = p1a; p1a = rv1;
        p2b = p1b; p1b = rv2;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("ready_lat1", 32'(ready1), 32'(rem == 0));
    chk("ready_lat2", 32'(ready2), 32'(rem == 0));
    chk("memdout_lat1", 32'(if1.memdout), 32'(p1a));
    chk("memdout_lat2", 32'(if2.memdout), 32'(p2b));
  endtask

  task automatic rnd(input bit allow_clr);
    en        = ($urandom_range(0, 3) != 0);
    memaddr   = 6'($urandom);
    host_we   = $urandom_range(0, 1) == 1;
    host_addr = ($urandom_range(0, 3) == 0) ? memaddr : 6'($urandom);
    host_din  = 14'($urandom);
    clr       = allow_clr && ($urandom_range(0, 99) == 0);
  endtask

  task automatic read_all();
    clr = 0; host_we = 0; en = 1;
    for (int a = 0; a < 64; a++) begin
      memaddr = 6'(a);
      tick();
    end
    tick();
    tick();
  endtask

  initial begin
    rst = 1; clr = 0; en = 0; host_we = 0;
    memaddr = '0; host_addr = '0; host_din = '0;
    rem = 64;
    p1a = '0; p2a = '0; p1b = '0; p2b = '0;
    @(negedge clk);
    tick();
    rst = 0;

    repeat (64) begin rnd(1'b0); tick(); end
    read_all();

    clr = 0; en = 1;
    host_we = 1; host_addr = 6'd5; host_din = 14'h2A5A; memaddr = 6'd0;
    tick();
    host_we = 0; memaddr = 6'd5;
    repeat (3) tick();

    host_we = 1; host_addr = 6'd9; host_din = 14'h1234; memaddr = 6'd9;
    tick();
    host_we = 0;
    repeat (2) tick();

    memaddr = 6'd9; tick();
    en = 0; memaddr = 6'd5; tick();
    memaddr = 6'd6; tick();
    tick();
    en = 1; repeat (3) tick();

    host_we = 1; host_addr = 6'd63; host_din = 14'h3FFF; tick();
    host_addr = 6'd10; host_din = 14'h1111; clr = 1; tick();
    repeat (64) begin rnd(1'b0); tick(); end
    clr = 0; host_we = 0; en = 1;
    memaddr = 6'd63; tick();
    memaddr = 6'd10; tick();
    repeat (2) tick();

    repeat (300) begin rnd(1'b1); tick(); end
    repeat (70) begin rnd(1'b0); tick(); end

    rnd(1'b0); clr = 1; tick();
    repeat (20) begin rnd(1'b0); tick(); end
    clr = 1; tick();
    repeat (30) begin rnd(1'b0); tick(); end
    rst = 1; host_we = 0; clr = 0; tick();
    rst = 0;
    repeat (64) begin rnd(1'b0); tick(); end
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
